// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types, sizes and boot image for the instruction memory
//
// Purpose : constants and types used by instr_mem and its bus interface.
// Contents: INSTR_* sizes, byte/address typedefs, NOP opcode and the
//           BOOT_IMAGE table that is loaded on reset when
//           INSTR_MEM_PRELOAD_EN is defined.
package instr_mem_pkg;

  localparam int INSTR_ADDR_W = 8;
  localparam int INSTR_DATA_W = 8;
  localparam int INSTR_DEPTH  = 256;
  localparam int INSTR_WR_W   = 2 * INSTR_DATA_W;

  typedef logic [INSTR_DATA_W-1:0] instr_byte_t;
  typedef logic [INSTR_ADDR_W-1:0] instr_addr_t;

  localparam instr_byte_t NOP = 8'h00;

  // Fixed program the core runs straight out of reset when preload is built in.
  localparam instr_byte_t BOOT_IMAGE [INSTR_DEPTH] = '{
    0: 8'h10, 1: 8'h21, 2: 8'h32, 3: 8'h43, 4: 8'h54,
    5: 8'h65, 6: 8'h76, 7: 8'h87, 8: 8'h98,
    default: NOP
  };

endpackage

// File: rtl/instr_mem_if.sv
// rtl/instr_mem_if.sv - loader write and fetch read bus of the instruction memory
//
// Purpose : bundles the loader write port and the fetch read port.
// Signals : we, w_instr[WR_W], w_addr[ADDR_W]  - loader write (low byte at w_addr)
//           r_addr[ADDR_W], r_instr[DATA_W]    - fetch address and registered data
// Modports: master - loader/fetch side, drives addresses, data and we
//           slave  - memory side, returns r_instr
interface instr_mem_if
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = INSTR_ADDR_W,
  parameter int DATA_W = INSTR_DATA_W,
  parameter int WR_W   = 2 * DATA_W
);

  logic              we;
  logic [WR_W-1:0]   w_instr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_instr;

  modport master (
    output we, w_instr, w_addr, r_addr,
    input  r_instr
  );

  modport slave (
    input  we, w_instr, w_addr, r_addr,
    output r_instr
  );

endinterface

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - byte-addressed instruction store, 16-bit write, 8-bit registered fetch
//
// Purpose : 2**ADDR_W x DATA_W instruction memory between the program loader
//           and the core fetch logic.
// Ports   : clk - rising-edge clock for storage and output register
//           rst - asynchronous active-high reset
//           bus - instr_mem_if.slave (we, w_instr, w_addr, r_addr, r_instr)
// Macro   : INSTR_MEM_PRELOAD_EN - reset loads BOOT_IMAGE instead of clearing.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = INSTR_ADDR_W,
  parameter int DATA_W = INSTR_DATA_W,
  parameter int WR_W   = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  instr_mem_if.slave        bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] r_instr_q;
  logic [DATA_W-1:0] r_instr_d;
  logic [ADDR_W-1:0] w_addr_hi;

  // High byte lands one address up; the add wraps naturally at the top.
  assign w_addr_hi = bus.w_addr + ADDR_W'(1);

  // Sampling the array before this edge's write gives read-first collisions.
  always_comb begin
    r_instr_d = mem_q[bus.r_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef INSTR_MEM_PRELOAD_EN
        mem_q[i[ADDR_W-1:0]] <= BOOT_IMAGE[i[INSTR_ADDR_W-1:0]];
`else
        mem_q[i[ADDR_W-1:0]] <= '0;
`endif
      end
    end else begin
      r_instr_q <= r_instr_d;
      if (bus.we) begin
        mem_q[bus.w_addr]  <= bus.w_instr[DATA_W-1:0];
        mem_q[w_addr_hi]   <= bus.w_instr[WR_W-1:DATA_W];
      end
    end
  end

  assign bus.r_instr = r_instr_q;

endmodule

// File: tb/tb_instr_mem.sv
// tb/tb_instr_mem.sv - directed and random scoreboard bench for instr_mem
module tb_instr_mem;
  import instr_mem_pkg::*;

  logic clk;
  logic rst;

  instr_mem_if bus ();

  instr_mem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  logic [7:0] model_mem [256];
  logic [7:0] exp_q [$];
  int checks;
  int errors;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
`ifdef INSTR_MEM_PRELOAD_EN
    model_mem[0] = 8'h10; model_mem[1] = 8'h21; model_mem[2] = 8'h32;
    model_mem[3] = 8'h43; model_mem[4] = 8'h54; model_mem[5] = 8'h65;
    model_mem[6] = 8'h76; model_mem[7] = 8'h87; model_mem[8] = 8'h98;
`endif
  endtask

  task automatic check_now(input string tag, input logic [7:0] expected);
    logic [7:0] got;
    got = bus.r_instr;
    checks++;
    assert (got === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, got, expected);
      end
  endtask

  // Drive one cycle of inputs, queue the expected fetch byte (pre-write
  // contents), update the model, then compare one edge later.
  task automatic step(input string tag, input logic we_v, input logic [7:0] wa,
                      input logic [15:0] wd, input logic [7:0] ra);
    logic [7:0] hi;
    logic [7:0] expected;
    bus.we      = we_v;
    bus.w_addr  = wa;
    bus.w_instr = wd;
    bus.r_addr  = ra;
    exp_q.push_back(model_mem[ra]);
    if (we_v) begin
      hi = wa + 8'd1;
      model_mem[wa] = wd[7:0];
      model_mem[hi] = wd[15:8];
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=%h expected=queued", tag, bus.r_instr);
    end else begin
      expected = exp_q.pop_front();
      check_now(tag, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.we = 1'b0;
    bus.w_addr = 8'h00;
    bus.w_instr = 16'h0000;
    bus.r_addr = 8'h00;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", 8'h00);
    rst = 1'b0;

    // Back-to-back reads of the first program bytes and the first blank byte.
    for (int a = 0; a <= 9; a++) step("boot_read", 1'b0, 8'h00, 16'h0000, 8'(a));

    // Write then read both bytes.
    step("write_beef", 1'b1, 8'h04, 16'hBEEF, 8'h00);
    step("read_lo",    1'b0, 8'h00, 16'h0000, 8'h04);
    check_now("beef_lo_const", 8'hEF);
    step("read_hi",    1'b0, 8'h00, 16'h0000, 8'h05);
    check_now("beef_hi_const", 8'hBE);

    // Address wrap on the high byte.
    step("write_wrap", 1'b1, 8'hFF, 16'h1234, 8'h01);
    step("wrap_lo",    1'b0, 8'h00, 16'h0000, 8'hFF);
    check_now("wrap_lo_const", 8'h34);
    step("wrap_hi",    1'b0, 8'h00, 16'h0000, 8'h00);
    check_now("wrap_hi_const", 8'h12);

    // Same-edge read/write collision is read-first.
    step("collide",    1'b1, 8'h07, 16'hAA55, 8'h07);
    step("after_coll", 1'b0, 8'h00, 16'h0000, 8'h07);
    check_now("after_coll_const", 8'h55);
    step("collide_hi", 1'b1, 8'h20, 16'h6699, 8'h21);
    step("after_hi",   1'b0, 8'h00, 16'h0000, 8'h21);

    // Mid-program reset: output clears without a clock edge, writes are ignored.
    step("write_cafe", 1'b1, 8'h02, 16'hCAFE, 8'h04);
    bus.we = 1'b0;
    #4;
    rst = 1'b1;
    #1;
    check_now("async_reset", 8'h00);
    bus.we = 1'b1;
    bus.w_addr = 8'h08;
    bus.w_instr = 16'h5A5A;
    bus.r_addr = 8'h04;
    @(posedge clk);
    #1;
    check_now("reset_hold", 8'h00);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    step("post_rst_2", 1'b0, 8'h00, 16'h0000, 8'h02);
    step("post_rst_3", 1'b0, 8'h00, 16'h0000, 8'h03);
    step("post_rst_8", 1'b0, 8'h00, 16'h0000, 8'h08);
    step("post_rst_9", 1'b0, 8'h00, 16'h0000, 8'h09);
    step("post_rst_4", 1'b0, 8'h00, 16'h0000, 8'h04);

    // Write port still works after reset.
    step("write_1357", 1'b1, 8'h10, 16'h1357, 8'h10);
    step("read_10",    1'b0, 8'h00, 16'h0000, 8'h10);
    step("read_11",    1'b0, 8'h00, 16'h0000, 8'h11);

    // Random mix over a small window so reads hit written bytes often.
    for (int n = 0; n < 40; n++) begin
      step("random", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
           16'($urandom), 8'($urandom_range(0, 16)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
